// File: rtl/rv32v_lane_mem_sequencer.sv
// -----------------------------------------------------------------------------
// rv32v_lane_mem_sequencer
// Per-lane vector memory sequencer sitting between the vector MEM stage and the
// load-store controller (LSC). One uop of NUM_LANES elements is accepted at a
// time. For each active lane, the block issues one scalar access, in ascending
// lane order. Masked lanes are skipped and cost no cycles.
// Load data is gathered per lane. A bus error aborts the uop and reports the
// faulting lane and its address.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   flush             abandon the current uop (highest priority)
//   req_*             uop request; accepted when req_valid & req_ready & ~flush
//   lsc_*             single-access handshake with the load-store controller
//   curr_lane         lane of the access currently presented to the LSC
//   busy              uop in progress
//   done / fault      one-cycle completion / abort pulses
//   res_data/res_wen  gathered load data and the lanes written by this uop
//   fault_lane/addr   faulting lane and address, held until the next accept
// -----------------------------------------------------------------------------
module rv32v_lane_mem_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 32,
    localparam int LANE_W   = $clog2(NUM_LANES)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_store,
    input  logic [1:0]                    req_mode,
    input  logic [1:0]                    req_eew,
    input  logic [ADDR_W-1:0]             req_uop_num,
    input  logic [ADDR_W-1:0]             req_base,
    input  logic [ADDR_W-1:0]             req_stride,
    input  logic [NUM_LANES*ADDR_W-1:0]   req_idx,
    input  logic [NUM_LANES*ADDR_W-1:0]   req_wdata,
    input  logic [NUM_LANES-1:0]          req_mask,
    output logic                          lsc_ren,
    output logic                          lsc_wen,
    output logic [ADDR_W-1:0]             lsc_addr,
    output logic [ADDR_W-1:0]             lsc_wdata,
    output logic [1:0]                    lsc_eew,
    input  logic                          lsc_ready,
    input  logic [ADDR_W-1:0]             lsc_rdata,
    input  logic                          lsc_error,
    output logic [LANE_W-1:0]             curr_lane,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_LANES*ADDR_W-1:0]   res_data,
    output logic [NUM_LANES-1:0]          res_wen,
    output logic                          fault,
    output logic [LANE_W-1:0]             fault_lane,
    output logic [ADDR_W-1:0]             fault_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;

    logic                          r_store;
    logic [1:0]                    r_mode;
    logic [1:0]                    r_eew;
    logic [ADDR_W-1:0]             r_uop;
    logic [ADDR_W-1:0]             r_base;
    logic [ADDR_W-1:0]             r_stride;
    logic [NUM_LANES*ADDR_W-1:0]   r_idx;
    logic [NUM_LANES*ADDR_W-1:0]   r_wdata;
    logic [NUM_LANES-1:0]          r_pend;
    logic [NUM_LANES*ADDR_W-1:0]   r_res_data;
    logic [NUM_LANES-1:0]          r_res_wen;
    logic [LANE_W-1:0]             r_fault_lane;
    logic [ADDR_W-1:0]             r_fault_addr;

    logic [LANE_W-1:0]             w_lane;
    logic [NUM_LANES-1:0]          w_pend_clr;
    logic [ADDR_W-1:0]             w_lane_idx;
    logic [ADDR_W-1:0]             w_lane_wdata;
    logic [ADDR_W-1:0]             w_elem;
    logic [1:0]                    w_shift;
    logic [ADDR_W-1:0]             w_addr;
    logic                          w_issue;

    assign w_issue = (r_state == ST_ISSUE);

    // Lowest set bit of the pending mask; scanning downwards lets the lowest win.
    always_comb begin
        w_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            w_lane = r_pend[l] ? LANE_W'(l) : w_lane;
        end
    end

    // Pending mask with the current lane retired.
    always_comb begin
        w_pend_clr         = r_pend;
        w_pend_clr[w_lane] = 1'b0;
    end

    // Per-lane index offset and store data of the current lane.
    always_comb begin
        w_lane_idx   = '0;
        w_lane_wdata = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_lane_idx   = (LANE_W'(l) == w_lane) ? r_idx[l*ADDR_W +: ADDR_W]   : w_lane_idx;
            w_lane_wdata = (LANE_W'(l) == w_lane) ? r_wdata[l*ADDR_W +: ADDR_W] : w_lane_wdata;
        end
    end

    // Element address; all arithmetic truncates to ADDR_W, so wrap-around is silent.
    // Reserved eew encoding behaves as 32-bit, reserved mode behaves as unit-stride.
    always_comb begin
        w_elem  = r_uop * ADDR_W'(NUM_LANES) + ADDR_W'(w_lane);
        w_shift = (r_eew == 2'd3) ? 2'd2 : r_eew;
        case (r_mode)
            2'd1:    w_addr = r_base + w_elem * r_stride;
            2'd2:    w_addr = r_base + w_lane_idx;
            default: w_addr = r_base + (w_elem << w_shift);
        endcase
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        w_next_state = (req_mask == '0) ? ST_DONE : ST_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (lsc_ready && lsc_error) begin
                        w_next_state = ST_FAULT;
                    end else if (lsc_ready && (w_pend_clr == '0)) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_ISSUE;
                    end
                end
                ST_DONE:  w_next_state = ST_IDLE;
                ST_FAULT: w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture, pending mask, result gathering and fault capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_store      <= 1'b0;
            r_mode       <= 2'd0;
            r_eew        <= 2'd0;
            r_uop        <= '0;
            r_base       <= '0;
            r_stride     <= '0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_pend       <= '0;
            r_res_data   <= '0;
            r_res_wen    <= '0;
            r_fault_lane <= '0;
            r_fault_addr <= '0;
        end else if (flush) begin
            // Results of a same-cycle completion are discarded.
            r_pend <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store      <= req_store;
                        r_mode       <= req_mode;
                        r_eew        <= req_eew;
                        r_uop        <= req_uop_num;
                        r_base       <= req_base;
                        r_stride     <= req_stride;
                        r_idx        <= req_idx;
                        r_wdata      <= req_wdata;
                        r_pend       <= req_mask;
                        r_res_data   <= '0;
                        r_res_wen    <= '0;
                        r_fault_lane <= '0;
                        r_fault_addr <= '0;
                    end else begin
                        r_pend <= r_pend;
                    end
                end
                ST_ISSUE: begin
                    if (lsc_ready && lsc_error) begin
                        r_fault_lane <= w_lane;
                        r_fault_addr <= w_addr;
                        r_pend       <= '0;
                    end else if (lsc_ready) begin
                        r_pend <= w_pend_clr;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (!r_store && (LANE_W'(l) == w_lane)) begin
                                r_res_data[l*ADDR_W +: ADDR_W] <= lsc_rdata;
                                r_res_wen[l]                   <= 1'b1;
                            end else begin
                                r_res_wen[l] <= r_res_wen[l];
                            end
                        end
                    end else begin
                        r_pend <= r_pend;
                    end
                end
                default: begin
                    r_pend <= r_pend;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign fault      = (r_state == ST_FAULT);
    assign lsc_ren    = w_issue & ~r_store;
    assign lsc_wen    = w_issue & r_store;
    assign lsc_addr   = w_issue ? w_addr : '0;
    assign lsc_wdata  = (w_issue && r_store) ? w_lane_wdata : '0;
    assign lsc_eew    = r_eew;
    assign curr_lane  = w_issue ? w_lane : '0;
    assign res_data   = r_res_data;
    assign res_wen    = r_res_wen;
    assign fault_lane = r_fault_lane;
    assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_rv32v_lane_mem_sequencer.sv
module tb_rv32v_lane_mem_sequencer;

    localparam logic [31:0] K = 32'hDEAD_0000;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [1:0]    req_mode = 2'd0;
    logic [1:0]    req_eew = 2'd0;
    logic [31:0]   req_uop_num = 32'd0;
    logic [31:0]   req_base = 32'd0;
    logic [31:0]   req_stride = 32'd0;
    logic [127:0]  req_idx = 128'd0;
    logic [127:0]  req_wdata = 128'd0;
    logic [3:0]    req_mask = 4'd0;
    logic          lsc_ren, lsc_wen;
    logic [31:0]   lsc_addr, lsc_wdata, lsc_rdata;
    logic [1:0]    lsc_eew;
    logic          lsc_ready = 1'b0;
    logic          lsc_error = 1'b0;
    logic [1:0]    curr_lane;
    logic          busy, done, fault;
    logic [127:0]  res_data;
    logic [3:0]    res_wen;
    logic [1:0]    fault_lane;
    logic [31:0]   fault_addr;

    logic          e8_req_valid = 1'b0;
    logic          e8_req_ready;
    logic [31:0]   e8_uop = 32'd0;
    logic [7:0]    e8_mask = 8'd0;
    logic          e8_ren, e8_wen;
    logic [31:0]   e8_addr, e8_wdata_o, e8_rdata;
    logic [1:0]    e8_eew_o;
    logic          e8_ready = 1'b0;
    logic [2:0]    e8_curr_lane;
    logic          e8_busy, e8_done, e8_fault;
    logic [255:0]  e8_res_data;
    logic [7:0]    e8_res_wen;
    logic [2:0]    e8_fault_lane;
    logic [31:0]   e8_fault_addr;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 CLK = ~CLK;

    assign lsc_rdata = lsc_addr ^ K;
    assign e8_rdata  = e8_addr ^ K;

    always @(posedge CLK) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    rv32v_lane_mem_sequencer #(.NUM_LANES(4), .ADDR_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_mode(req_mode), .req_eew(req_eew), .req_uop_num(req_uop_num),
        .req_base(req_base), .req_stride(req_stride), .req_idx(req_idx), .req_wdata(req_wdata),
        .req_mask(req_mask), .lsc_ren(lsc_ren), .lsc_wen(lsc_wen), .lsc_addr(lsc_addr),
        .lsc_wdata(lsc_wdata), .lsc_eew(lsc_eew), .lsc_ready(lsc_ready), .lsc_rdata(lsc_rdata),
        .lsc_error(lsc_error), .curr_lane(curr_lane), .busy(busy), .done(done),
        .res_data(res_data), .res_wen(res_wen), .fault(fault), .fault_lane(fault_lane),
        .fault_addr(fault_addr)
    );

    rv32v_lane_mem_sequencer #(.NUM_LANES(8), .ADDR_W(32)) u_dut8 (
        .CLK(CLK), .RST(RST), .flush(1'b0), .req_valid(e8_req_valid), .req_ready(e8_req_ready),
        .req_store(1'b0), .req_mode(2'd0), .req_eew(2'd0), .req_uop_num(e8_uop),
        .req_base(32'd0), .req_stride(32'd0), .req_idx(256'd0), .req_wdata(256'd0),
        .req_mask(e8_mask), .lsc_ren(e8_ren), .lsc_wen(e8_wen), .lsc_addr(e8_addr),
        .lsc_wdata(e8_wdata_o), .lsc_eew(e8_eew_o), .lsc_ready(e8_ready), .lsc_rdata(e8_rdata),
        .lsc_error(1'b0), .curr_lane(e8_curr_lane), .busy(e8_busy), .done(e8_done),
        .res_data(e8_res_data), .res_wen(e8_res_wen), .fault(e8_fault), .fault_lane(e8_fault_lane),
        .fault_addr(e8_fault_addr)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic st, input logic [1:0] md, input logic [1:0] ew,
                          input logic [31:0] uop, input logic [31:0] base, input logic [31:0] stride,
                          input logic [127:0] idx, input logic [127:0] wd, input logic [3:0] m);
        req_store = st; req_mode = md; req_eew = ew; req_uop_num = uop; req_base = base;
        req_stride = stride; req_idx = idx; req_wdata = wd; req_mask = m; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_ready got ready=%b busy=%b exp 1/0", req_ready, busy); end
        checks++; if ({lsc_ren, lsc_wen, done, fault} !== 4'b0000) begin failures++; $display("FAIL reset_pulses got %b exp 0000", {lsc_ren, lsc_wen, done, fault}); end
        checks++; if (res_data !== 128'd0 || res_wen !== 4'd0) begin failures++; $display("FAIL reset_res got data=%h wen=%b exp 0", res_data, res_wen); end
        checks++; if (fault_lane !== 2'd0 || fault_addr !== 32'd0 || lsc_addr !== 32'd0) begin failures++; $display("FAIL reset_fault got lane=%0d addr=%h exp 0", fault_lane, fault_addr); end
    endtask

    task automatic test_unit();
        logic [31:0] exp;
        lsc_ready = 1'b1;
        accept(1'b0, 2'd0, 2'd2, 32'd1, 32'h1000, 32'd0, 128'd0, 128'd0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp = 32'h1010 + 32'd4 * i;
            checks++; if (lsc_ren !== 1'b1 || lsc_addr !== exp || curr_lane !== 2'(i)) begin failures++; $display("FAIL unit_addr lane %0d got ren=%b addr=%h cl=%0d exp 1 %h", i, lsc_ren, lsc_addr, curr_lane, exp); end
            checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL unit_busy lane %0d got busy=%b ready=%b done=%b", i, busy, req_ready, done); end
            step();
        end
        checks++; if (done !== 1'b1 || res_wen !== 4'hF) begin failures++; $display("FAIL unit_done got done=%b wen=%b exp 1 1111", done, res_wen); end
        checks++; if (res_data !== {32'h101C ^ K, 32'h1018 ^ K, 32'h1014 ^ K, 32'h1010 ^ K}) begin failures++; $display("FAIL unit_data got %h", res_data); end
        step();
        checks++; if (done !== 1'b0 || req_ready !== 1'b1 || lsc_ren !== 1'b0) begin failures++; $display("FAIL unit_idle got done=%b ready=%b ren=%b exp 0 1 0", done, req_ready, lsc_ren); end
    endtask

    task automatic test_strided();
        logic [31:0] exp;
        int lanes [2] = '{0, 2};
        lsc_ready = 1'b1;
        accept(1'b0, 2'd1, 2'd2, 32'd0, 32'h1000, 32'h100, 128'd0, 128'd0, 4'b0101);
        for (int i = 0; i < 2; i++) begin
            exp = 32'h1000 + 32'h100 * lanes[i];
            checks++; if (lsc_ren !== 1'b1 || lsc_addr !== exp || curr_lane !== 2'(lanes[i])) begin failures++; $display("FAIL strided_addr got addr=%h cl=%0d exp %h %0d", lsc_addr, curr_lane, exp, lanes[i]); end
            step();
        end
        checks++; if (done !== 1'b1 || res_wen !== 4'b0101) begin failures++; $display("FAIL strided_done got done=%b wen=%b exp 1 0101", done, res_wen); end
        checks++; if (res_data !== {32'd0, 32'h1200 ^ K, 32'd0, 32'h1000 ^ K}) begin failures++; $display("FAIL strided_data got %h", res_data); end
        step();
    endtask

    task automatic test_indexed();
        logic [31:0] exp;
        lsc_ready = 1'b0;
        accept(1'b0, 2'd2, 2'd2, 32'd5, 32'h2000, 32'd0, {32'hC, 32'h8, 32'h4, 32'h0}, 128'd0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp = 32'h2000 + 32'd4 * i;
            for (int w = 0; w < 3; w++) begin
                checks++; if (lsc_ren !== 1'b1 || lsc_addr !== exp || curr_lane !== 2'(i)) begin failures++; $display("FAIL indexed_wait lane %0d w %0d got ren=%b addr=%h exp %h", i, w, lsc_ren, lsc_addr, exp); end
                step();
            end
            lsc_ready = 1'b1;
            checks++; if (lsc_addr !== exp) begin failures++; $display("FAIL indexed_addr lane %0d got %h exp %h", i, lsc_addr, exp); end
            step();
            lsc_ready = 1'b0;
        end
        checks++; if (done !== 1'b1 || res_wen !== 4'hF) begin failures++; $display("FAIL indexed_done got done=%b wen=%b", done, res_wen); end
        checks++; if (res_data !== {32'h200C ^ K, 32'h2008 ^ K, 32'h2004 ^ K, 32'h2000 ^ K}) begin failures++; $display("FAIL indexed_data got %h", res_data); end
        step();
    endtask

    task automatic test_store();
        lsc_ready = 1'b1;
        accept(1'b1, 2'd0, 2'd0, 32'd0, 32'h3000, 32'd0, 128'd0, {32'h0, 32'h0, 32'hBBBB0001, 32'hAAAA0000}, 4'b0011);
        checks++; if (lsc_wen !== 1'b1 || lsc_ren !== 1'b0 || lsc_addr !== 32'h3000 || lsc_wdata !== 32'hAAAA0000) begin failures++; $display("FAIL store_l0 got wen=%b ren=%b addr=%h wd=%h", lsc_wen, lsc_ren, lsc_addr, lsc_wdata); end
        step();
        checks++; if (lsc_wen !== 1'b1 || lsc_addr !== 32'h3001 || lsc_wdata !== 32'hBBBB0001 || curr_lane !== 2'd1) begin failures++; $display("FAIL store_l1 got addr=%h wd=%h cl=%0d", lsc_addr, lsc_wdata, curr_lane); end
        step();
        checks++; if (done !== 1'b1 || res_wen !== 4'd0 || lsc_wen !== 1'b0) begin failures++; $display("FAIL store_done got done=%b wen=%b", done, res_wen); end
        step();
    endtask

    task automatic test_zero_mask();
        accept(1'b0, 2'd0, 2'd2, 32'd0, 32'h1000, 32'd0, 128'd0, 128'd0, 4'b0000);
        checks++; if (done !== 1'b1 || lsc_ren !== 1'b0 || lsc_wen !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_done got done=%b ren=%b wen=%b busy=%b", done, lsc_ren, lsc_wen, busy); end
        step();
        checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL zero_idle got done=%b ready=%b", done, req_ready); end
    endtask

    task automatic test_fault();
        lsc_ready = 1'b1;
        accept(1'b0, 2'd0, 2'd2, 32'd0, 32'h1000, 32'd0, 128'd0, 128'd0, 4'hF);
        step(); step();
        checks++; if (curr_lane !== 2'd2 || lsc_addr !== 32'h1008) begin failures++; $display("FAIL fault_pre got cl=%0d addr=%h exp 2 1008", curr_lane, lsc_addr); end
        lsc_error = 1'b1;
        step();
        lsc_error = 1'b0;
        checks++; if (fault !== 1'b1 || done !== 1'b0 || lsc_ren !== 1'b0) begin failures++; $display("FAIL fault_pulse got fault=%b done=%b ren=%b", fault, done, lsc_ren); end
        checks++; if (fault_lane !== 2'd2 || fault_addr !== 32'h1008 || res_wen !== 4'b0011) begin failures++; $display("FAIL fault_info got lane=%0d addr=%h wen=%b exp 2 1008 0011", fault_lane, fault_addr, res_wen); end
        step();
        checks++; if (fault !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || fault_lane !== 2'd2) begin failures++; $display("FAIL fault_hold got fault=%b done=%b ready=%b lane=%0d", fault, done, req_ready, fault_lane); end
    endtask

    task automatic test_flush();
        int d0;
        d0 = done_cnt;
        lsc_ready = 1'b1;
        accept(1'b0, 2'd0, 2'd2, 32'd0, 32'h1000, 32'd0, 128'd0, 128'd0, 4'hF);
        step();
        checks++; if (curr_lane !== 2'd1) begin failures++; $display("FAIL flush_lane got %0d exp 1", curr_lane); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || lsc_ren !== 1'b0 || done !== 1'b0 || res_wen !== 4'b0001) begin failures++; $display("FAIL flush_abort got busy=%b ren=%b done=%b wen=%b", busy, lsc_ren, done, res_wen); end
        accept(1'b0, 2'd0, 2'd2, 32'd0, 32'h4000, 32'd0, 128'd0, 128'd0, 4'b0010);
        checks++; if (lsc_addr !== 32'h4004 || curr_lane !== 2'd1) begin failures++; $display("FAIL flush_next_addr got %h exp 4004", lsc_addr); end
        step();
        checks++; if (done !== 1'b1 || res_wen !== 4'b0010 || res_data[63:32] !== (32'h4004 ^ K)) begin failures++; $display("FAIL flush_next_done got done=%b wen=%b", done, res_wen); end
        step();
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL flush_done_count got %0d exp %0d", done_cnt, d0 + 1); end
        flush = 1'b1;
        req_mask = 4'hF; req_valid = 1'b1;
        step();
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (busy !== 1'b0 || lsc_ren !== 1'b0) begin failures++; $display("FAIL flush_idle_req got busy=%b ren=%b exp 0 0", busy, lsc_ren); end
    endtask

    task automatic test_lanes8();
        e8_ready = 1'b1;
        e8_uop = 32'd2; e8_mask = 8'h81; e8_req_valid = 1'b1;
        step();
        e8_req_valid = 1'b0;
        checks++; if (e8_ren !== 1'b1 || e8_addr !== 32'h10 || e8_curr_lane !== 3'd0) begin failures++; $display("FAIL l8_lane0 got addr=%h cl=%0d exp 10 0", e8_addr, e8_curr_lane); end
        step();
        checks++; if (e8_addr !== 32'h17 || e8_curr_lane !== 3'd7) begin failures++; $display("FAIL l8_lane7 got addr=%h cl=%0d exp 17 7", e8_addr, e8_curr_lane); end
        step();
        checks++; if (e8_done !== 1'b1 || e8_res_wen !== 8'h81 || e8_res_data[255:224] !== (32'h17 ^ K)) begin failures++; $display("FAIL l8_done got done=%b wen=%h", e8_done, e8_res_wen); end
        step();
    endtask

    initial begin
        test_reset();
        test_unit();
        test_strided();
        test_indexed();
        test_store();
        test_zero_mask();
        test_fault();
        test_flush();
        test_lanes8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
